// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: picks a box from the LFSR, shows the mole for a
// fixed number of ticks, judges whacks and keeps score, misses and round count.
module mole_scheduler #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int SHOW_TICKS = 2,
    parameter int GAP_TICKS  = 1,
    parameter int MAX_ROUNDS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] hit,
    input  logic [2:0] lfsr_state,
    output logic       lfsr_enable,
    output logic [3:0] mole_onehot,
    output logic [2:0] mole_box,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [7:0] round,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       wrong_pulse,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_SHOW, S_GAP, S_OVER} state_t;

    localparam int TCW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TNW  = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
    localparam logic [TNW-1:0] SHOW_LAST  = TNW'(SHOW_TICKS - 1);
    localparam logic [TNW-1:0] GAP_LAST   = TNW'(GAP_TICKS - 1);
    localparam logic [7:0]     ROUND_LAST = 8'(MAX_ROUNDS);

    state_t           state_reg, state_next;
    logic [TCW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [TNW-1:0]   tick_num_reg, tick_num_next;
    logic [2:0]       mole_box_reg, mole_box_next;
    logic [3:0]       mole_onehot_reg;
    logic [2:0]       last_box_reg, last_box_next;
    logic [7:0]       score_reg, score_next;
    logic [7:0]       misses_reg, misses_next;
    logic [7:0]       round_reg, round_next;
    logic             hit_pulse_reg, hit_pulse_next;
    logic             miss_pulse_reg, miss_pulse_next;
    logic             wrong_pulse_reg, wrong_pulse_next;

    logic             tick;
    logic             hit_match;
    logic             hit_other;
    logic [2:0]       candidate;
    logic [7:0]       round_inc;
    logic [3:0]       onehot_dec;

    // 001/010/100 -> 1, 011/101 -> 2, 110 -> 3, 000/111 -> 4
    function automatic logic [2:0] map_box(input logic [2:0] s);
        logic [2:0] b;
        case (s)
            3'b001, 3'b010, 3'b100: b = 3'd1;
            3'b011, 3'b101:         b = 3'd2;
            3'b110:                 b = 3'd3;
            default:                b = 3'd4;
        endcase
        return b;
    endfunction

    assign tick      = (tick_cnt_reg == TICK_LAST);
    assign hit_match = |(hit & mole_onehot_reg);
    assign hit_other = |(hit & ~mole_onehot_reg);
    assign candidate = map_box(lfsr_state);
    assign round_inc = round_reg + 8'd1;

    // Lit-box decode of the next box so the one-hot output is registered with it
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign onehot_dec[gi] = (mole_box_next == 3'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            tick_cnt_reg    <= '0;
            tick_num_reg    <= '0;
            mole_box_reg    <= 3'd0;
            mole_onehot_reg <= 4'd0;
            last_box_reg    <= 3'd0;
            score_reg       <= 8'd0;
            misses_reg      <= 8'd0;
            round_reg       <= 8'd0;
            hit_pulse_reg   <= 1'b0;
            miss_pulse_reg  <= 1'b0;
            wrong_pulse_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tick_cnt_reg    <= tick_cnt_next;
            tick_num_reg    <= tick_num_next;
            mole_box_reg    <= mole_box_next;
            mole_onehot_reg <= onehot_dec;
            last_box_reg    <= last_box_next;
            score_reg       <= score_next;
            misses_reg      <= misses_next;
            round_reg       <= round_next;
            hit_pulse_reg   <= hit_pulse_next;
            miss_pulse_reg  <= miss_pulse_next;
            wrong_pulse_reg <= wrong_pulse_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        tick_cnt_next    = tick ? '0 : tick_cnt_reg + 1'b1;
        tick_num_next    = tick ? tick_num_reg + 1'b1 : tick_num_reg;
        mole_box_next    = mole_box_reg;
        last_box_next    = last_box_reg;
        score_next       = score_reg;
        misses_next      = misses_reg;
        round_next       = round_reg;
        hit_pulse_next   = 1'b0;
        miss_pulse_next  = 1'b0;
        wrong_pulse_next = 1'b0;

        case (state_reg)
            S_IDLE, S_OVER: begin
                mole_box_next = 3'd0;
                if (start) begin
                    score_next    = 8'd0;
                    misses_next   = 8'd0;
                    round_next    = 8'd0;
                    last_box_next = 3'd0;
                    state_next    = S_PICK;
                end
            end
            S_PICK: begin
                // Never show the same box twice in a row; the LFSR keeps moving
                if (candidate != last_box_reg) begin
                    mole_box_next = candidate;
                    last_box_next = candidate;
                    tick_cnt_next = '0;
                    tick_num_next = '0;
                    state_next    = S_SHOW;
                end
            end
            S_SHOW: begin
                if (hit_match) begin
                    score_next     = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
                    hit_pulse_next = 1'b1;
                    mole_box_next  = 3'd0;
                    tick_cnt_next  = '0;
                    tick_num_next  = '0;
                    state_next     = S_GAP;
                end else begin
                    wrong_pulse_next = hit_other;
                    if (tick && tick_num_reg == SHOW_LAST) begin
                        misses_next     = (misses_reg == 8'hFF) ? misses_reg : misses_reg + 8'd1;
                        miss_pulse_next = 1'b1;
                        mole_box_next   = 3'd0;
                        tick_cnt_next   = '0;
                        tick_num_next   = '0;
                        state_next      = S_GAP;
                    end
                end
            end
            S_GAP: begin
                mole_box_next = 3'd0;
                if (tick && tick_num_reg == GAP_LAST) begin
                    round_next = round_inc;
                    state_next = (round_inc == ROUND_LAST) ? S_OVER : S_PICK;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign lfsr_enable = ~reset;
    assign mole_onehot = mole_onehot_reg;
    assign mole_box    = mole_box_reg;
    assign score       = score_reg;
    assign misses      = misses_reg;
    assign round       = round_reg;
    assign hit_pulse   = hit_pulse_reg;
    assign miss_pulse  = miss_pulse_reg;
    assign wrong_pulse = wrong_pulse_reg;
    assign busy        = (state_reg == S_PICK) || (state_reg == S_SHOW) || (state_reg == S_GAP);
    assign game_over   = (state_reg == S_OVER);

endmodule
